// File: rtl/pcm_delay_pkg.sv
// pcm_delay_pkg: default geometry constants and the PCM sample type for the delay array
package pcm_delay_pkg;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 19;
  localparam int MAX_DELAY = 31;
  localparam int DLY_W = 5;
  typedef logic signed [DATA_W-1:0] pcm_t;
endpackage

// File: rtl/pcm_delay_ring.sv
// pcm_delay_ring: one channel's circular history buffer; ports clk/rst, we (write strobe), wr_ptr (shared write address), dly (delay for this sample), fill (warm-up count), din (sample in), dout (registered delayed sample)
module pcm_delay_ring #(
  parameter int DATA_W = pcm_delay_pkg::DATA_W,
  parameter int DLY_W = pcm_delay_pkg::DLY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DLY_W-1:0]  wr_ptr,
  input  logic [DLY_W-1:0]  dly,
  input  logic [DLY_W-1:0]  fill,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  import pcm_delay_pkg::*;
  localparam int DEPTH = 1 << DLY_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DLY_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  // Zero delay bypasses the write so the current sample is returned rather than stale memory.
  always_comb begin
    rd_addr = wr_ptr - dly;
    rd_data = fill < dly ? '0 : dly == '0 ? din : mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else if (we) dout <= rd_data;
  end
endmodule

// File: rtl/pcm_delay_array.sv
// pcm_delay_array: multichannel integer-sample delay line with shadowed, atomically committed per-channel delays; ports clk/rst, in_valid/pcm_in (sample set), cfg_we/cfg_ch/cfg_delay (shadow write), cfg_commit, out_valid/pcm_out (delayed set), commit_pending
module pcm_delay_array #(
  parameter int NUM_CH = pcm_delay_pkg::NUM_CH,
  parameter int DATA_W = pcm_delay_pkg::DATA_W,
  parameter int MAX_DELAY = pcm_delay_pkg::MAX_DELAY,
  parameter int DLY_W = pcm_delay_pkg::DLY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   pcm_in,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [DLY_W-1:0]           cfg_delay,
  input  logic                       cfg_commit,
  output logic                       out_valid,
  output logic [NUM_CH*DATA_W-1:0]   pcm_out,
  output logic                       commit_pending
);
  import pcm_delay_pkg::*;
  logic [DLY_W-1:0] wr_ptr, fill, cfg_clamp;
  logic [DLY_W-1:0] shadow [NUM_CH];
  logic [DLY_W-1:0] shadow_nxt [NUM_CH];
  logic [DLY_W-1:0] d_act [NUM_CH];
  logic [DLY_W-1:0] d_eff [NUM_CH];
  logic apply;
  // A commit lands on the sample it coincides with, including any same-cycle shadow write.
  always_comb begin
    cfg_clamp = cfg_delay > DLY_W'(MAX_DELAY) ? DLY_W'(MAX_DELAY) : cfg_delay;
    apply = in_valid && (commit_pending || cfg_commit);
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_nxt[i] = cfg_we && int'(cfg_ch) == i ? cfg_clamp : shadow[i];
      d_eff[i] = apply ? shadow_nxt[i] : d_act[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill <= '0;
      out_valid <= 1'b0;
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        d_act[i] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      commit_pending <= !in_valid && (commit_pending || cfg_commit);
      shadow <= shadow_nxt;
      d_act <= d_eff;
      if (in_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill <= fill == DLY_W'(MAX_DELAY) ? fill : fill + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pcm_delay_ring #(.DATA_W(DATA_W), .DLY_W(DLY_W)) u_ring (
      .clk(clk),
      .rst(rst),
      .we(in_valid && !rst),
      .wr_ptr(wr_ptr),
      .dly(d_eff[g]),
      .fill(fill),
      .din(pcm_in[g*DATA_W +: DATA_W]),
      .dout(pcm_out[g*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_pcm_delay_array.sv
// tb_pcm_delay_array: directed scoreboard bench for pcm_delay_array
module tb_pcm_delay_array;
  import pcm_delay_pkg::*;
  localparam int W = NUM_CH * DATA_W;
  localparam int CH_W = $clog2(NUM_CH);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic cfg_we = 1'b0;
  logic cfg_commit = 1'b0;
  logic [W-1:0] pcm_in = '0;
  logic [W-1:0] pcm_out;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic out_valid, commit_pending;
  int nchk = 0;
  int nfail = 0;
  logic [W-1:0] hist [$];
  logic [W-1:0] expq [$];
  int sh_m [NUM_CH];
  int act_m [NUM_CH];
  bit pend_m;

  always #5 clk = ~clk;

  pcm_delay_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pcm_in(pcm_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_commit(cfg_commit),
    .out_valid(out_valid), .pcm_out(pcm_out), .commit_pending(commit_pending)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) chk("unexpected_out_valid", out_valid, '0);
      else chk("pcm_out", pcm_out, expq.pop_front());
    end
  end

  function automatic logic [W-1:0] ramp(input int n);
    logic [W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(n + c);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  task automatic step(input bit v, input logic [W-1:0] d, input bit we = 0, input int ch = 0,
                      input int dly = 0, input bit cm = 0);
    logic [W-1:0] e, h;
    int n, a, dt;
    @(negedge clk);
    in_valid = v; pcm_in = d; cfg_we = we; cfg_ch = CH_W'(ch);
    cfg_delay = DLY_W'(dly); cfg_commit = cm;
    dt = dly % (1 << DLY_W);
    if (we) sh_m[ch] = dt > MAX_DELAY ? MAX_DELAY : dt;
    if (v) begin
      if (pend_m || cm) act_m = sh_m;
      pend_m = 0;
      hist.push_back(d);
      n = hist.size() - 1;
      e = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        a = act_m[c];
        if (n >= a) begin
          h = hist[n - a];
          e[c*DATA_W +: DATA_W] = h[c*DATA_W +: DATA_W];
        end
      end
      expq.push_back(e);
    end else if (cm) pend_m = 1;
  endtask

  task automatic idle(input int k = 1);
    repeat (k) step(0, '0);
  endtask

  task automatic reset_dut(input bit v);
    @(negedge clk);
    rst = 1'b1; in_valid = v; pcm_in = rnd(); cfg_we = 0; cfg_commit = 0;
    hist.delete();
    pend_m = 0;
    for (int c = 0; c < NUM_CH; c++) begin sh_m[c] = 0; act_m[c] = 0; end
    @(negedge clk);
    rst = 1'b0; in_valid = 0;
    chk("rst_pcm_out", pcm_out, '0);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_commit_pending", commit_pending, '0);
  endtask

  task automatic set_all(input int d);
    for (int c = 0; c < NUM_CH; c++) step(0, '0, 1, c, d);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut(0);
    for (int n = 0; n < 8; n++) step(1, ramp(n));
    idle(2);

    reset_dut(0);
    for (int c = 0; c < NUM_CH; c++) step(0, '0, 1, c, c);
    step(0, '0, 0, 0, 0, 1);
    idle();
    chk("pending_after_commit", commit_pending, 1);
    for (int n = 1; n <= 40; n++) step(1, ramp(n));
    idle();
    chk("pending_cleared", commit_pending, 0);

    step(0, '0, 1, 3, MAX_DELAY, 1);
    for (int n = 41; n <= 80; n++) step(1, rnd());
    idle();

    set_all(4);
    step(0, '0, 0, 0, 0, 1);
    idle(2);
    step(0, '0, 0, 0, 0, 1);
    chk("pending_held", commit_pending, 1);
    idle(3);
    step(1, rnd());
    chk("pending_before_sample", commit_pending, 1);
    idle();
    chk("pending_applied", commit_pending, 0);
    for (int n = 0; n < 10; n++) step(1, rnd());
    step(1, rnd(), 1, 5, 2, 1);
    for (int n = 0; n < 6; n++) step(1, rnd());
    idle();
    chk("pending_immediate", commit_pending, 0);

    reset_dut(0);
    set_all(MAX_DELAY);
    step(0, '0, 0, 0, 0, 1);
    for (int n = 0; n < 200; n++) begin
      step(1, rnd());
      idle($urandom_range(0, 3));
    end
    idle();

    reset_dut(0);
    set_all(8);
    step(0, '0, 0, 0, 0, 1);
    for (int n = 0; n < 50; n++) step(1, rnd());
    reset_dut(1);
    set_all(8);
    step(0, '0, 0, 0, 0, 1);
    for (int n = 0; n < 12; n++) step(1, rnd());
    idle(3);
    chk("scoreboard_drained", W'(expq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
